// File: rtl/mux_pkg.sv
// Shared constants and helpers for the rr_mux_n stream multiplexer.
// Mode encodings and round-robin pointer arithmetic.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int unsigned ptr_inc(
    input int unsigned g,
    input int unsigned ch
  );
    return (g == ch - 32'd1) ? 32'd0 : g + 32'd1;
  endfunction

  function automatic int unsigned idx_add(
    input int unsigned a,
    input int unsigned b,
    input int unsigned ch
  );
    int unsigned s;
    s = a + b;
    if (s >= ch) s = s - ch;
    return s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate by ptr,
// priority-encode the lowest request, then un-rotate.
module rr_pick
  import mux_pkg::*;
#(
  parameter int CH = 4,
  parameter int SW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  logic [CH-1:0] rot;
  logic [SW-1:0] off;
  logic          vld;

  always_comb begin
    rot = '0;
    for (int i = 0; i < CH; i++) begin
      rot[i] = req[SW'(idx_add(32'(ptr), i, CH))];
    end
  end

  always_comb begin
    off = '0;
    vld = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        vld = 1'b1;
        off = SW'(i);
      end
    end
  end

  assign gnt_vld = vld;
  assign gnt_idx = SW'(idx_add(32'(ptr), 32'(off), CH));

endmodule

// File: rtl/rr_mux_n.sv
// Registered N-channel stream mux with round-robin or fixed select.
// One holding register on the output; input side is purely combinational.
module rr_mux_n
  import mux_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   fix_sel,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          fix_vld;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic          load_en;
  logic          xfer;
  logic [W-1:0]  sel_data;

  rr_pick #(
    .CH (CH),
    .SW (SW)
  ) u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // out-of-range fix_sel matches no channel, so it grants nothing
  always_comb begin
    fix_vld = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (fix_sel == SW'(k) && in_valid[k]) fix_vld = 1'b1;
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    unique case (mode)
      MODE_RR: begin
        gnt_vld = rr_vld;
        gnt_idx = rr_idx;
      end
      MODE_FIXED: begin
        gnt_vld = fix_vld;
        gnt_idx = fix_sel;
      end
      default: ;
    endcase
  end

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = load_en && gnt_vld;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (gnt_idx == SW'(k)) begin
        in_ready[k] = xfer;
        sel_data    = in_data[k*W +: W];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    unique case (1'b1)
      xfer: begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_ch_d    = gnt_idx;
        if (mode == MODE_RR) begin
          ptr_d = SW'(ptr_inc(32'(gnt_idx), CH));
        end
      end
      (!xfer && out_ready): begin
        out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
